// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator car control slice.
// Scheduler FSM encoding, sweep direction values and default floor count.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        MOVING   = 2'd2
    } sched_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEF_NUM_FLOORS = 4;

endpackage

// File: rtl/scan_picker.sv
// SCAN target picker: current floor first, then nearest ahead, then reverse.
// Two priority encoders search strictly above and strictly below cur_floor.
module scan_picker
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    pick_floor,
    output logic                  pick_dir_up
);

    logic               up_hit;
    logic               dn_hit;
    logic [FLOOR_W-1:0] up_idx;
    logic [FLOOR_W-1:0] dn_idx;

    // Descending scan leaves the lowest floor above; ascending the highest below.
    always_comb begin
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
                up_hit = 1'b1;
                up_idx = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        dn_hit = 1'b0;
        dn_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
                dn_hit = 1'b1;
                dn_idx = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found       = |pending;
        pick_floor  = cur_floor;
        pick_dir_up = dir_up;
        if (pending[cur_floor]) begin
            pick_floor  = cur_floor;
            pick_dir_up = dir_up;
        end else if (dir_up == DIR_UP) begin
            if (up_hit) begin
                pick_floor  = up_idx;
                pick_dir_up = DIR_UP;
            end else if (dn_hit) begin
                pick_floor  = dn_idx;
                pick_dir_up = DIR_DN;
            end
        end else begin
            if (dn_hit) begin
                pick_floor  = dn_idx;
                pick_dir_up = DIR_DN;
            end else if (up_hit) begin
                pick_floor  = up_idx;
                pick_dir_up = DIR_UP;
            end
        end
    end

endmodule

// File: rtl/floor_request_sched.sv
// Floor request scheduler: request latch, SCAN pick, valid/ready dispatch
// and arrival-based completion of the served floor.
module floor_request_sched
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrived,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    input  logic                  target_ready,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  idle
);

    localparam logic [FLOOR_W:0] FLOOR_LIM = (FLOOR_W + 1)'(NUM_FLOORS);

    sched_state_t          state;
    logic                  found;
    logic [FLOOR_W-1:0]    pick_floor;
    logic                  pick_dir_up;
    logic [NUM_FLOORS-1:0] clr_mask;

    scan_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .pending     (pending),
        .cur_floor   (cur_floor),
        .dir_up      (dir_up),
        .found       (found),
        .pick_floor  (pick_floor),
        .pick_dir_up (pick_dir_up)
    );

    // Service clear is applied after the button OR so it wins a same-cycle press.
    always_comb begin
        clr_mask = '0;
        if (state == MOVING && arrived)
            clr_mask = NUM_FLOORS'(1) << target_floor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending      <= '0;
            dir_up       <= DIR_UP;
            target_valid <= 1'b0;
            target_floor <= '0;
        end else begin
            pending <= (pending | btn) & ~clr_mask;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        target_floor <= pick_floor;
                        dir_up       <= pick_dir_up;
                        target_valid <= 1'b1;
                        state        <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (target_ready) begin
                        target_valid <= 1'b0;
                        state        <= MOVING;
                    end
                end
                MOVING: begin
                    if (arrived)
                        state <= IDLE;
                end
                default: begin
                    target_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign idle = (state == IDLE) && (pending == '0);

    a_cur_floor_range: assert property (
        @(posedge clk) disable iff (!rst_n) {1'b0, cur_floor} < FLOOR_LIM
    );

endmodule

// File: tb/tb_floor_request_sched.sv
// Directed bench for floor_request_sched: 4-floor and 16-floor instances.
module tb_floor_request_sched;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  btn;
    logic [1:0]  cur;
    logic        arrived;
    logic        ready;
    logic        valid;
    logic [1:0]  tfloor;
    logic [3:0]  pend;
    logic        dir;
    logic        idl;

    logic [15:0] b16;
    logic [3:0]  c16;
    logic        arr16;
    logic        rdy16;
    logic        v16;
    logic [3:0]  t16;
    logic [15:0] p16;
    logic        d16;
    logic        i16;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    floor_request_sched #(.NUM_FLOORS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .cur_floor    (cur),
        .arrived      (arrived),
        .target_valid (valid),
        .target_floor (tfloor),
        .target_ready (ready),
        .pending      (pend),
        .dir_up       (dir),
        .idle         (idl)
    );

    floor_request_sched #(.NUM_FLOORS(16)) dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (b16),
        .cur_floor    (c16),
        .arrived      (arr16),
        .target_valid (v16),
        .target_floor (t16),
        .target_ready (rdy16),
        .pending      (p16),
        .dir_up       (d16),
        .idle         (i16)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn = '0; cur = '0; arrived = 1'b0; ready = 1'b0;
        b16 = '0; c16 = '0; arr16 = 1'b0; rdy16 = 1'b0;
        #12;
        chk("rst_pend",  32'(pend),   32'h0);
        chk("rst_dir",   32'(dir),    32'h1);
        chk("rst_valid", 32'(valid),  32'h0);
        chk("rst_floor", 32'(tfloor), 32'h0);
        chk("rst_idle",  32'(idl),    32'h1);
        step();
        rst_n = 1'b1;
        step();

        // single request above, ready held high
        ready = 1'b1;
        btn = 4'b1000;
        step();
        btn = '0;
        chk("t1_pend",   32'(pend),  32'h8);
        chk("t1_idle",   32'(idl),   32'h0);
        chk("t1_v0",     32'(valid), 32'h0);
        step();
        chk("t1_valid",  32'(valid),  32'h1);
        chk("t1_floor",  32'(tfloor), 32'h3);
        chk("t1_dir",    32'(dir),    32'h1);
        step();
        chk("t1_oneclk", 32'(valid), 32'h0);
        arrived = 1'b1;
        step();
        arrived = 1'b0;
        chk("t1_clr",    32'(pend), 32'h0);
        chk("t1_idle2",  32'(idl),  32'h1);

        // SCAN from floor 1 going up, frozen target while stalled
        ready = 1'b0;
        cur = 2'd1;
        btn = 4'b1001;
        step();
        btn = '0;
        chk("t2_pend",   32'(pend), 32'h9);
        step();
        chk("t2_valid",  32'(valid),  32'h1);
        chk("t2_floor",  32'(tfloor), 32'h3);
        chk("t2_dir",    32'(dir),    32'h1);
        for (int k = 0; k < 5; k++) begin
            btn = (k == 0) ? 4'b0100 : 4'b0000;
            arrived = (k == 2);
            step();
            chk("t2_hold_floor", 32'(tfloor), 32'h3);
            chk("t2_hold_valid", 32'(valid),  32'h1);
        end
        btn = '0;
        arrived = 1'b0;
        chk("t2_pend2",  32'(pend), 32'hD);
        ready = 1'b1;
        step();
        chk("t2_accept", 32'(valid), 32'h0);
        cur = 2'd3;
        arrived = 1'b1;
        btn = 4'b1000;
        step();
        arrived = 1'b0;
        btn = '0;
        chk("t2_clrwin", 32'(pend), 32'h5);
        chk("t2_idle",   32'(idl),  32'h0);
        step();
        chk("t2_v2",     32'(valid),  32'h1);
        chk("t2_f2",     32'(tfloor), 32'h2);
        chk("t2_d2",     32'(dir),    32'h0);
        step();
        cur = 2'd2;
        arrived = 1'b1;
        step();
        arrived = 1'b0;
        chk("t2_pend3",  32'(pend), 32'h1);
        step();
        chk("t2_v3",     32'(valid),  32'h1);
        chk("t2_f3",     32'(tfloor), 32'h0);
        chk("t2_d3",     32'(dir),    32'h0);
        step();
        chk("t2_v3off",  32'(valid), 32'h0);
        cur = 2'd0;
        arrived = 1'b1;
        step();
        chk("t2_empty",  32'(pend), 32'h0);
        chk("t2_idle2",  32'(idl),  32'h1);

        // arrived while idle is ignored
        step();
        arrived = 1'b0;
        chk("t3_pend",   32'(pend),  32'h0);
        chk("t3_idle",   32'(idl),   32'h1);
        chk("t3_valid",  32'(valid), 32'h0);

        // request at current floor keeps direction (down)
        cur = 2'd2;
        btn = 4'b0100;
        step();
        btn = '0;
        step();
        chk("t4_valid",  32'(valid),  32'h1);
        chk("t4_floor",  32'(tfloor), 32'h2);
        chk("t4_dir",    32'(dir),    32'h0);
        step();
        btn = 4'b0010;
        step();
        btn = '0;
        chk("t4_pend",   32'(pend), 32'h6);

        // asynchronous reset mid-cycle in MOVING
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pend",   32'(pend),   32'h0);
        chk("ar_dir",    32'(dir),    32'h1);
        chk("ar_valid",  32'(valid),  32'h0);
        chk("ar_floor",  32'(tfloor), 32'h0);
        chk("ar_idle",   32'(idl),    32'h1);
        step();
        rst_n = 1'b1;
        step();

        // 16 floors: from 15 going up, requests at 15 and 0
        c16 = 4'd15;
        rdy16 = 1'b1;
        b16 = 16'h8001;
        step();
        b16 = '0;
        chk("f16_pend",  32'(p16), 32'h8001);
        step();
        chk("f16_v1",    32'(v16), 32'h1);
        chk("f16_f1",    32'(t16), 32'hF);
        chk("f16_d1",    32'(d16), 32'h1);
        step();
        arr16 = 1'b1;
        step();
        arr16 = 1'b0;
        chk("f16_pend2", 32'(p16), 32'h1);
        step();
        chk("f16_v2",    32'(v16), 32'h1);
        chk("f16_f2",    32'(t16), 32'h0);
        chk("f16_d2",    32'(d16), 32'h0);
        step();
        c16 = 4'd0;
        arr16 = 1'b1;
        step();
        arr16 = 1'b0;
        chk("f16_empty", 32'(p16), 32'h0);
        chk("f16_idle",  32'(i16), 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/floor_request_sched.md
# floor_request_sched

Parametrised floor-request scheduler for the elevator car. It latches hall/car button presses for `NUM_FLOORS` floors into a pending mask and picks the next target floor with a SCAN (keep-direction) policy. It hands the target to the motion controller over a valid/ready handshake, then waits for an arrival pulse before clearing the served request. It replaces the fixed four-button, last-press-wins stage selector with queued requests, direction memory and explicit completion tracking.

## Interface
Parameters:
- `NUM_FLOORS`, default 4: number of floors; legal range 2..16.
- `FLOOR_W`, default `$clog2(NUM_FLOORS)`, minimum 1: width of floor indices.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn`, input, NUM_FLOORS: request buttons, bit i = floor i. Already debounced and synchronous; level-sensitive.
- `cur_floor`, input, FLOOR_W: current car floor from the motion controller. Must be < NUM_FLOORS.
- `arrived`, input, 1: one-cycle pulse, car stopped at the dispatched target.
- `target_valid`, output, 1: a target is offered.
- `target_floor`, output, FLOOR_W: offered or active target.
- `target_ready`, input, 1: controller accepts the target.
- `pending`, output, NUM_FLOORS: latched request mask, used for button lamps.
- `dir_up`, output, 1: current sweep direction; 1 = up.
- `idle`, output, 1: high in IDLE with `pending == 0`.

## Operation
- Request latch: `pending[i]` sets on any cycle `btn[i]` = 1. It clears only on service.
- Service: in MOVING with `arrived` = 1, `pending[target_floor]` clears. If `btn[target_floor]` is pressed in the same cycle, the clear wins.
- FSM states: IDLE, DISPATCH, MOVING.
- IDLE:
  - If `pending != 0`, run the pick, register `target_floor` and `dir_up`, and go to DISPATCH.
  - Otherwise stay in IDLE.
- DISPATCH:
  - `target_valid` = 1.
  - `target_floor` and `dir_up` are frozen, even if new or nearer requests arrive.
  - On `target_valid && target_ready`, go to MOVING.
- MOVING:
  - `target_valid` = 0.
  - New requests latch but never retarget the car.
  - `arrived` = 1 clears the served bit and returns to IDLE.
  - `arrived` in IDLE or DISPATCH is ignored.
- Pick rule, in priority order:
  1. `pending[cur_floor]` set → target = `cur_floor`; direction unchanged.
  2. Else, nearest pending floor strictly in the `dir_up` direction.
  3. Else, nearest pending floor in the opposite direction, and `dir_up` flips.
- Wrap-around: none. Floor 0 and floor NUM_FLOORS-1 are hard ends; the direction flip handles reversal.
- An out-of-range `cur_floor` is a protocol violation and is flagged by a simulation assertion.

## Timing
- Reset values: `pending` = 0, `dir_up` = 1, state IDLE, `target_valid` = 0, `target_floor` = 0, `idle` = 1.
- Reset mid-operation drops all requests and any outstanding target immediately.
- `btn` high at edge t → `pending` bit visible after edge t, and `idle` falls the same cycle.
- From IDLE, `target_valid` rises one cycle after `pending` becomes non-zero. Latency from press to offer is 2 cycles.
- Acceptance: ready seen at edge t → `target_valid` low after edge t.
- `target_ready` may be held high permanently; each offer then lasts exactly one cycle.
- Arrival: `arrived` at edge t → bit cleared and state IDLE after edge t. The next offer appears one cycle later if requests remain.
- All outputs are registered except `idle`, which is decoded from state and the `pending` register.

## Structure
- Shared package `elev_pkg`:
  - `sched_state_t` enum (IDLE, DISPATCH, MOVING).
  - Direction constants `DIR_UP` = 1, `DIR_DN` = 0.
  - Default `NUM_FLOORS` constant.
- One combinational sub-module, `scan_picker`:
  - Inputs: `pending`, `cur_floor`, `dir_up`.
  - Outputs: `found`, `pick_floor`, `pick_dir_up`.
  - Implemented as two priority encoders, one searching above and one below `cur_floor`.
- The top module holds the latch, the FSM and the handshake.

## Test plan
- Reset, then `btn` = 4'b1000 at cur 0 with ready high → `target_valid` for one cycle, 2 cycles after the press, floor 3, `dir_up` = 1. `arrived` → `pending` = 0, `idle` = 1.
- Car at 1, `dir_up` = 1, pending {0, 3} → target 3 first. After arrival at 3, target 0 with `dir_up` = 0.
- Ready held low in DISPATCH for 5 cycles while `btn[2]` is pressed (nearer) → `target_floor` stays stable at the original value; `pending` shows both bits.
- `arrived` pulsed in IDLE and in DISPATCH → no state or `pending` change. Press of the target floor coincident with `arrived` → bit ends cleared.
- Request at `cur_floor` = 2 while idle → target 2, direction unchanged. With NUM_FLOORS = 16, requests at 15 and 0 from floor 15 going up → 15, then 0 with a flip.
- `rst_n` asserted low in MOVING with `pending` non-zero → all outputs return to reset values asynchronously, before the next clock edge.
